// File: rtl/channel_concat.sv
// Decoder skip-connection merge: per pixel, CH_A channels of stream A then
// CH_B channels of stream B, with regenerated line/frame framing.
module channel_concat #(
  parameter int DATA_WIDTH   = 8,
  parameter int STRING_LEN   = 448,
  parameter int CH_A         = 3,
  parameter int CH_B         = 3,
  parameter int FIFO_A_DEPTH = 2048,
  parameter int FIFO_B_DEPTH = 4096
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] a_data_i,
  input  logic                  a_valid_i,
  input  logic                  a_sof_i,
  input  logic [DATA_WIDTH-1:0] b_data_i,
  input  logic                  b_valid_i,
  input  logic                  b_sof_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_valid_o,
  output logic                  sop_o,
  output logic                  eop_o,
  output logic                  sof_o,
  output logic                  eof_o,
  output logic                  ovf_a_o,
  output logic                  ovf_b_o,
  output logic                  sync_err_o
);

  localparam int DW1 = DATA_WIDTH + 1;
  localparam int AWA = $clog2(FIFO_A_DEPTH);
  localparam int AWB = $clog2(FIFO_B_DEPTH);
  localparam int CWA = AWA + 1;
  localparam int CWB = AWB + 1;
  localparam int PW  = $clog2(STRING_LEN + 1);
  localparam int CW  = $clog2(CH_A + CH_B + 1);

  localparam logic [CWA-1:0] DEP_A  = CWA'(FIFO_A_DEPTH);
  localparam logic [CWB-1:0] DEP_B  = CWB'(FIFO_B_DEPTH);
  localparam logic [CWA-1:0] NEED_A = CWA'(CH_A);
  localparam logic [CWB-1:0] NEED_B = CWB'(CH_B);
  localparam logic [7:0]     KA     = 8'(CH_A - 1);
  localparam logic [7:0]     KB     = 8'(CH_B - 1);
  localparam logic [PW-1:0]  PLAST  = PW'(STRING_LEN - 1);
  localparam logic [CW-1:0]  CLAST  = CW'(CH_A + CH_B - 1);

  typedef enum logic [1:0] {IDLE, EMIT_A, EMIT_B} state_t;

  logic [DW1-1:0] mem_a [FIFO_A_DEPTH];
  logic [DW1-1:0] mem_b [FIFO_B_DEPTH];
  logic [AWA-1:0] wp_a_q, rp_a_q;
  logic [AWB-1:0] wp_b_q, rp_b_q;
  logic [CWA-1:0] cnt_a_q;
  logic [CWB-1:0] cnt_b_q;
  logic           ovf_a_q, ovf_b_q;

  state_t         state_q, state_d;
  logic [7:0]     k_q, k_d;
  logic           rd_a, rd_b, wr_a, wr_b;
  logic           avail, first_a, first_b, px_done;

  logic [PW-1:0]  ipix_q, iline_q;
  logic           rv_q, chk_q, exp_q;
  logic [DW1-1:0] rdat_q;

  logic [DATA_WIDTH-1:0] data_q;
  logic           dv_q, serr_q;
  logic [CW-1:0]  chan_q;
  logic [PW-1:0]  pix_q, line_q;

  // A write into a full FIFO is still taken when a read frees a slot that cycle.
  assign wr_a = a_valid_i && ((cnt_a_q != DEP_A) || rd_a);
  assign wr_b = b_valid_i && ((cnt_b_q != DEP_B) || rd_b);

  assign rd_b  = (state_q == EMIT_B);
  assign avail = (cnt_a_q >= NEED_A) &&
                 ((cnt_b_q - CWB'(rd_b)) >= NEED_B);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    rd_a    = 1'b0;
    first_a = 1'b0;
    first_b = 1'b0;
    px_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (avail) begin
          rd_a    = 1'b1;
          first_a = 1'b1;
          if (KA == 8'd0) begin
            state_d = EMIT_B;
            k_d     = 8'd0;
          end else begin
            state_d = EMIT_A;
            k_d     = 8'd1;
          end
        end
      end
      EMIT_A: begin
        rd_a    = 1'b1;
        first_a = (k_q == 8'd0);
        if (k_q == KA) begin
          state_d = EMIT_B;
          k_d     = 8'd0;
        end else begin
          k_d = k_q + 8'd1;
        end
      end
      EMIT_B: begin
        first_b = (k_q == 8'd0);
        if (k_q == KB) begin
          px_done = 1'b1;
          k_d     = 8'd0;
          state_d = avail ? EMIT_A : IDLE;
        end else begin
          k_d = k_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_a) mem_a[wp_a_q] <= {a_sof_i, a_data_i};
    if (wr_b) mem_b[wp_b_q] <= {b_sof_i, b_data_i};
    if (rd_a)      rdat_q <= mem_a[rp_a_q];
    else if (rd_b) rdat_q <= mem_b[rp_b_q];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_a_q  <= '0;
      rp_a_q  <= '0;
      cnt_a_q <= '0;
      wp_b_q  <= '0;
      rp_b_q  <= '0;
      cnt_b_q <= '0;
      ovf_a_q <= 1'b0;
      ovf_b_q <= 1'b0;
    end else begin
      if (wr_a) wp_a_q <= wp_a_q + AWA'(1);
      if (rd_a) rp_a_q <= rp_a_q + AWA'(1);
      if (wr_b) wp_b_q <= wp_b_q + AWB'(1);
      if (rd_b) rp_b_q <= rp_b_q + AWB'(1);
      unique case ({wr_a, rd_a})
        2'b10:   cnt_a_q <= cnt_a_q + CWA'(1);
        2'b01:   cnt_a_q <= cnt_a_q - CWA'(1);
        default: ;
      endcase
      unique case ({wr_b, rd_b})
        2'b10:   cnt_b_q <= cnt_b_q + CWB'(1);
        2'b01:   cnt_b_q <= cnt_b_q - CWB'(1);
        default: ;
      endcase
      ovf_a_q <= ovf_a_q | (a_valid_i & ~wr_a);
      ovf_b_q <= ovf_b_q | (b_valid_i & ~wr_b);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      ipix_q  <= '0;
      iline_q <= '0;
      rv_q    <= 1'b0;
      chk_q   <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      rv_q    <= rd_a | rd_b;
      chk_q   <= first_a | first_b;
      exp_q   <= (ipix_q == '0) && (iline_q == '0);
      // Issue-side pixel position, used only for the frame-start tag check.
      if (px_done) begin
        if (ipix_q == PLAST) begin
          ipix_q  <= '0;
          iline_q <= (iline_q == PLAST) ? '0 : iline_q + PW'(1);
        end else begin
          ipix_q <= ipix_q + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      dv_q   <= 1'b0;
      serr_q <= 1'b0;
      chan_q <= '0;
      pix_q  <= '0;
      line_q <= '0;
    end else begin
      dv_q <= rv_q;
      if (rv_q) data_q <= rdat_q[DATA_WIDTH-1:0];
      serr_q <= serr_q | (chk_q & (rdat_q[DATA_WIDTH] != exp_q));
      if (dv_q) begin
        if (chan_q == CLAST) begin
          chan_q <= '0;
          if (pix_q == PLAST) begin
            pix_q  <= '0;
            line_q <= (line_q == PLAST) ? '0 : line_q + PW'(1);
          end else begin
            pix_q <= pix_q + PW'(1);
          end
        end else begin
          chan_q <= chan_q + CW'(1);
        end
      end
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = dv_q;
  assign sop_o        = dv_q && (chan_q == '0) && (pix_q == '0);
  assign eop_o        = dv_q && (chan_q == CLAST) && (pix_q == PLAST);
  assign sof_o        = sop_o && (line_q == '0);
  assign eof_o        = eop_o && (line_q == PLAST);
  assign ovf_a_o      = ovf_a_q;
  assign ovf_b_o      = ovf_b_q;
  assign sync_err_o   = serr_q;

endmodule

// File: tb/tb_channel_concat.sv
// Scoreboard bench for channel_concat: directed pixels, expected words queued
// at issue, checked by a monitor whenever data_valid_o is high.
module tb_channel_concat;

  localparam int SL = 4;
  localparam int CH = 6;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] a_data_i = '0, b_data_i = '0;
  logic       a_valid_i = 1'b0, b_valid_i = 1'b0;
  logic       a_sof_i = 1'b0, b_sof_i = 1'b0;
  logic [7:0] data_o;
  logic       data_valid_o, sop_o, eop_o, sof_o, eof_o;
  logic       ovf_a_o, ovf_b_o, sync_err_o;

  channel_concat #(
    .DATA_WIDTH(8), .STRING_LEN(SL), .CH_A(3), .CH_B(3),
    .FIFO_A_DEPTH(16), .FIFO_B_DEPTH(16)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .a_data_i(a_data_i), .a_valid_i(a_valid_i), .a_sof_i(a_sof_i),
    .b_data_i(b_data_i), .b_valid_i(b_valid_i), .b_sof_i(b_sof_i),
    .data_o(data_o), .data_valid_o(data_valid_o),
    .sop_o(sop_o), .eop_o(eop_o), .sof_o(sof_o), .eof_o(eof_o),
    .ovf_a_o(ovf_a_o), .ovf_b_o(ovf_b_o), .sync_err_o(sync_err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] d;
    logic sop, eop, sof, eof;
  } exp_t;

  exp_t expq[$];
  int   ocyc[$];
  int   widx, nout, n_sop, n_eop, n_sof, n_eof;
  int   pass_n, tot_n;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    tot_n++;
    if (act === req) pass_n++;
    else $display("FAIL %s: got %0h want %0h", nm, act, req);
  endtask

  task automatic push(input logic [7:0] d);
    exp_t e;
    int ch, px, ln;
    ch = widx % CH;
    px = (widx / CH) % SL;
    ln = (widx / (CH * SL)) % SL;
    e.d   = d;
    e.sop = (ch == 0) && (px == 0);
    e.eop = (ch == CH - 1) && (px == SL - 1);
    e.sof = e.sop && (ln == 0);
    e.eof = e.eop && (ln == SL - 1);
    expq.push_back(e);
    widx++;
  endtask

  task automatic push_px(input logic [7:0] a0, input logic [7:0] b0);
    for (int c = 0; c < 3; c++) push(a0 + 8'(c));
    for (int c = 0; c < 3; c++) push(b0 + 8'(c));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic av, input logic [7:0] ad, input logic as_,
                     input logic bv, input logic [7:0] bd, input logic bs);
    a_valid_i = av; a_data_i = ad; a_sof_i = as_;
    b_valid_i = bv; b_data_i = bd; b_sof_i = bs;
    tick();
    a_valid_i = 1'b0; a_sof_i = 1'b0;
    b_valid_i = 1'b0; b_sof_i = 1'b0;
  endtask

  // Pixel written as three A words then three B words, one word per cycle.
  task automatic px_serial(input logic [7:0] a0, input logic as_,
                           input logic [7:0] b0, input logic bs);
    for (int c = 0; c < 3; c++)
      drv(1'b1, a0 + 8'(c), as_ && c == 0, 1'b0, 8'h0, 1'b0);
    for (int c = 0; c < 3; c++)
      drv(1'b0, 8'h0, 1'b0, 1'b1, b0 + 8'(c), bs && c == 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    expq.delete();
    widx = 0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 200 && expq.size() != 0; i++) tick();
    chk(nm, expq.size(), 0);
    repeat (8) tick();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, data_valid_o, 0);
    chk({nm, "_data"}, data_o, 0);
    chk({nm, "_flags"}, {sop_o, eop_o, sof_o, eof_o}, 0);
    chk({nm, "_sticky"}, {ovf_a_o, ovf_b_o, sync_err_o}, 0);
  endtask

  initial begin
    int base, tw, s0, e0, f0, g0;
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (data_valid_o) begin
          nout++;
          ocyc.push_back(cyc);
          n_sop += int'(sop_o);
          n_eop += int'(eop_o);
          n_sof += int'(sof_o);
          n_eof += int'(eof_o);
          if (expq.size() == 0) begin
            tot_n++;
            $display("FAIL unexpected_word: got %0h want none", data_o);
          end else begin
            e = expq.pop_front();
            chk("word", {data_o, sop_o, eop_o, sof_o, eof_o},
                {e.d, e.sop, e.eop, e.sof, e.eof});
          end
        end
      end
    join_none

    #2;
    reset_n = 1'b0;
    #3;
    chk_zero("reset");
    do_reset();

    // Single pixel, both streams concurrently.
    base = nout;
    push_px(8'd1, 8'd10);
    drv(1'b1, 8'd1, 1'b1, 1'b1, 8'd10, 1'b1);
    drv(1'b1, 8'd2, 1'b0, 1'b1, 8'd11, 1'b0);
    tw = cyc;
    drv(1'b1, 8'd3, 1'b0, 1'b1, 8'd12, 1'b0);
    drain("t1_drain");
    chk("t1_count", nout - base, 6);
    chk("t1_latency", ocyc[base] - tw, 3);
    chk("t1_consec", ocyc[base + 5] - ocyc[base], 5);
    chk("t1_sync", sync_err_o, 0);
    do_reset();

    // Full frame: B line 0 first, then A line 0, then interleaved lines.
    base = nout;
    s0 = n_sop; e0 = n_eop; f0 = n_sof; g0 = n_eof;
    for (int p = 0; p < SL; p++)
      for (int c = 0; c < 3; c++)
        drv(1'b0, 8'h0, 1'b0, 1'b1, 8'(100 + p * 3 + c), p == 0 && c == 0);
    chk("t2_no_early", nout - base, 0);
    tw = 0;
    for (int p = 0; p < SL; p++) begin
      push_px(8'(p * 3 + 1), 8'(100 + p * 3));
      for (int c = 0; c < 3; c++) begin
        if (p == 0 && c == 2) tw = cyc;
        drv(1'b1, 8'(p * 3 + c + 1), p == 0 && c == 0, 1'b0, 8'h0, 1'b0);
      end
    end
    for (int p = SL; p < SL * SL; p++) begin
      push_px(8'(p * 3 + 1), 8'(100 + p * 3));
      px_serial(8'(p * 3 + 1), 1'b0, 8'(100 + p * 3), 1'b0);
    end
    drain("t3_drain");
    chk("t2_first_lat", ocyc[base] - tw, 3);
    chk("t2_line0_gapless", ocyc[base + 23] - ocyc[base], 23);
    chk("t3_words", nout - base, 96);
    chk("t3_sop", n_sop - s0, 4);
    chk("t3_eop", n_eop - e0, 4);
    chk("t3_sof", n_sof - f0, 1);
    chk("t3_eof", n_eof - g0, 1);
    chk("t3_sticky", {ovf_a_o, ovf_b_o, sync_err_o}, 0);
    do_reset();

    // Frame-start tag on B pixel 1 instead of pixel 0.
    push_px(8'h21, 8'h31);
    px_serial(8'h21, 1'b1, 8'h31, 1'b0);
    chk("t5_before", sync_err_o, 0);
    push_px(8'h24, 8'h34);
    px_serial(8'h24, 1'b0, 8'h34, 1'b1);
    drain("t5_drain");
    chk("t5_err", sync_err_o, 1);
    repeat (5) tick();
    chk("t5_sticky", sync_err_o, 1);
    do_reset();

    // Reset after two output words of a pixel.
    base = nout;
    push_px(8'h50, 8'h58);
    drv(1'b1, 8'h50, 1'b1, 1'b1, 8'h58, 1'b1);
    drv(1'b1, 8'h51, 1'b0, 1'b1, 8'h59, 1'b0);
    drv(1'b1, 8'h52, 1'b0, 1'b1, 8'h5a, 1'b0);
    for (int i = 0; i < 30 && nout - base < 2; i++) begin
      @(negedge clk);
      #2;
    end
    chk("t6_two_words", nout - base, 2);
    reset_n = 1'b0;
    expq.delete();
    widx = 0;
    #1;
    chk_zero("t6_rst");
    repeat (2) tick();
    chk_zero("t6_rst_hold");
    reset_n = 1'b1;
    tick();
    base = nout;
    push_px(8'h70, 8'h78);
    drv(1'b1, 8'h70, 1'b1, 1'b1, 8'h78, 1'b1);
    drv(1'b1, 8'h71, 1'b0, 1'b1, 8'h79, 1'b0);
    drv(1'b1, 8'h72, 1'b0, 1'b1, 8'h7a, 1'b0);
    drain("t6_drain");
    chk("t6_count", nout - base, 6);
    chk("t6_sync", sync_err_o, 0);
    do_reset();

    // B overflow with A idle.
    for (int i = 1; i <= 20; i++) begin
      drv(1'b0, 8'h0, 1'b0, 1'b1, 8'(i), i == 1);
      if (i == 16) chk("t4_ovf_at16", ovf_b_o, 0);
      if (i == 17) chk("t4_ovf_at17", ovf_b_o, 1);
    end
    chk("t4_cnt_b", 32'(dut.cnt_b_q), 16);
    chk("t4_ovf_a", ovf_a_o, 0);
    chk("t4_ovf_b", ovf_b_o, 1);
    repeat (5) tick();
    chk("t4_no_out", data_valid_o, 0);
    do_reset();
    chk("t4_ovf_clr", ovf_b_o, 0);

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
